// File: rtl/mul8_pkg.sv
// Shared types and constants for the 8x8 multiplier operand sequencer.
package mul8_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned PROD_W    = 2 * WIDTH_DEF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/mul8_op_sequencer_if.sv
// Operand, multiplier and product handshake bundle of the sequencer.
// slave is the sequencer's view; master is its environment.
interface mul8_op_sequencer_if
  import mul8_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic [CNT_W-1:0]   fifo_count;
  logic               err_timeout;
  logic               err_clr;

  modport master (
    output in_valid, in_a, in_b, mul_done, mul_product, out_ready, err_clr,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_product, fifo_count, err_timeout
  );

  modport slave (
    input  in_valid, in_a, in_b, mul_done, mul_product, out_ready, err_clr,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_product, fifo_count, err_timeout
  );

endinterface

// File: rtl/mul8_op_fifo.sv
// Synchronous DEPTH-entry FIFO with head read-through; DEPTH must be a power of two.
module mul8_op_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_data,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // Requests are qualified here so callers cannot overflow or underflow.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/mul8_op_sequencer.sv
// Buffers operand pairs, issues them one at a time to the sequential multiplier,
// and holds each product until the consumer takes it; a watchdog aborts stuck operations.
module mul8_op_sequencer
  import mul8_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input logic                wb_clk_i,
  input logic                wb_rst_i,
  mul8_op_sequencer_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  seq_state_e         r_state;
  seq_state_e         w_state_d;
  logic               w_pop;
  logic               w_capture;
  logic               w_timeout;
  logic               w_full;
  logic               w_empty;
  logic [2*WIDTH-1:0] w_head;
  logic [CNT_W-1:0]   w_count;

  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_out_product;
  logic               r_err;
  logic [WD_W-1:0]    r_wd;

  mul8_op_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (bus.in_valid),
    .i_data  ({bus.in_a, bus.in_b}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      // A held product blocks issue so a completion never overwrites it.
      StIdle: begin
        if (!w_empty && !r_out_valid) begin
          w_pop     = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        w_state_d = StWait;
      end
      StWait: begin
        if (bus.mul_done) begin
          w_capture = 1'b1;
          w_state_d = StIdle;
        end else if (r_wd == WD_LAST) begin
          w_timeout = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
      r_err         <= 1'b0;
      r_wd          <= '0;
    end else begin
      if (w_pop) begin
        r_mul_a <= w_head[2*WIDTH-1:WIDTH];
        r_mul_b <= w_head[WIDTH-1:0];
      end

      if (r_state == StIssue) begin
        r_wd <= '0;
      end else if (r_state == StWait && !w_capture && !w_timeout) begin
        r_wd <= r_wd + WD_W'(1);
      end

      if (w_capture) begin
        r_out_product <= bus.mul_product;
        r_out_valid   <= 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      // A timeout in the same cycle as a clear request keeps the flag set.
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = !w_full;
  assign bus.mul_start   = (r_state == StIssue);
  assign bus.mul_a       = r_mul_a;
  assign bus.mul_b       = r_mul_b;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_product = r_out_product;
  assign bus.fifo_count  = w_count;
  assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_mul8_op_sequencer.sv
// Directed and randomized bench for mul8_op_sequencer against a transaction-level model.
module tb_mul8_op_sequencer;
  import mul8_pkg::*;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 32;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;

  mul8_op_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mul8_op_sequencer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Multiplier model: done strobe a fixed number of cycles after each start.
  bit          rand_mode = 0;
  bit          mm_hang   = 0;
  bit          mm_pending = 0;
  bit          mm_hang_cur = 0;
  int          mm_due = 0;
  logic [15:0] mm_res = '0;

  // Reference model state: FIFO contents, cycles since issue, held product, error flag.
  op_pair_t    m_q[$];
  op_pair_t    m_cur;
  int          m_age  = 0;
  bit          m_ov   = 0;
  bit          m_err  = 0;
  logic [15:0] m_prod = '0;
  bit          chk_en = 0;

  int          n_starts = 0;
  int          start_cyc = 0;
  logic [7:0]  start_a, start_b;
  logic [15:0] got_prod[$];

  always @(negedge wb_clk_i) begin
    bit push, issue, set_err;
    int lat;

    if (mm_pending && cyc == mm_due) begin
      bus.mul_done    = !mm_hang_cur;
      bus.mul_product = mm_res;
      mm_pending      = 0;
    end else begin
      bus.mul_done    = 1'b0;
      bus.mul_product = 16'($urandom);
    end

    if (chk_en) begin
      chk("in_ready",    bus.in_ready,    m_q.size() < DEPTH);
      chk("fifo_count",  bus.fifo_count,  m_q.size());
      chk("mul_start",   bus.mul_start,   m_age == 1);
      if (m_age == 1) begin
        chk("mul_a", bus.mul_a, m_cur.a);
        chk("mul_b", bus.mul_b, m_cur.b);
      end
      chk("out_valid",   bus.out_valid,   m_ov);
      chk("out_product", bus.out_product, m_prod);
      chk("err_timeout", bus.err_timeout, m_err);
    end

    if (bus.mul_start === 1'b1) begin
      n_starts++;
      start_cyc   = cyc;
      start_a     = bus.mul_a;
      start_b     = bus.mul_b;
      lat         = rand_mode ? int'($urandom_range(1, 12)) : 9;
      mm_hang_cur = rand_mode ? ($urandom_range(0, 9) == 0) : mm_hang;
      mm_due      = cyc + lat;
      mm_res      = 16'(bus.mul_a) * 16'(bus.mul_b);
      mm_pending  = 1;
    end

    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got_prod.push_back(bus.out_product);

    if (wb_rst_i === 1'b1) begin
      m_q.delete();
      m_age  = 0;
      m_ov   = 0;
      m_err  = 0;
      m_prod = '0;
      chk_en = 1;
    end else if (chk_en) begin
      push    = bus.in_valid && (m_q.size() < DEPTH);
      issue   = (m_age == 0) && (m_q.size() != 0) && !m_ov;
      set_err = 0;
      if (m_ov && bus.out_ready) m_ov = 0;
      if (m_age == 1) begin
        m_age = 2;
      end else if (m_age >= 2) begin
        if (bus.mul_done) begin
          m_ov   = 1;
          m_prod = bus.mul_product;
          m_age  = 0;
        end else if (m_age == int'(TIMEOUT) + 1) begin
          set_err = 1;
          m_age   = 0;
        end else begin
          m_age++;
        end
      end
      if (set_err) m_err = 1;
      else if (bus.err_clr) m_err = 0;
      if (issue) begin
        m_cur = m_q.pop_front();
        m_age = 1;
      end
      if (push) m_q.push_back('{a: bus.in_a, b: bus.in_b});
    end
  end

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, output int pc);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (bus.in_ready !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) bound_fail("push_ready");
    pc = cyc;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ov(output int t);
    int k = 0;
    while (bus.out_valid !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) bound_fail("wait_out_valid");
    t = cyc;
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    while (n_starts < n && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) bound_fail("wait_start");
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got_prod.size() < n && k < 400) begin
      step();
      k++;
    end
    if (k >= 400) bound_fail("wait_product");
  endtask

  initial begin
    int pc, t, base, gbase;
    logic [7:0] a3[6];
    logic [7:0] b3[6];

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    bus.err_clr   = 1'b0;
    wb_rst_i      = 1'b1;
    repeat (2) step();
    wb_rst_i = 1'b0;

    chk("rst_in_ready",    bus.in_ready,    1);
    chk("rst_fifo_count",  bus.fifo_count,  0);
    chk("rst_out_valid",   bus.out_valid,   0);
    chk("rst_out_product", bus.out_product, 0);
    chk("rst_err",         bus.err_timeout, 0);
    chk("rst_mul_start",   bus.mul_start,   0);

    // 13 x 11: start two cycles after the push, product one cycle after done.
    base = n_starts;
    push(8'd13, 8'd11, pc);
    wait_starts(base + 1);
    chk("t1_start_cycle", start_cyc, pc + 2);
    chk("t1_mul_a", start_a, 13);
    chk("t1_mul_b", start_b, 11);
    wait_ov(t);
    chk("t1_ov_cycle", t, start_cyc + 10);
    chk("t1_product", bus.out_product, 16'h008F);
    step();
    chk("t1_ov_drop", bus.out_valid, 0);

    base  = n_starts;
    gbase = got_prod.size();
    push(8'd255, 8'd255, pc);
    push(8'd0, 8'd7, pc);
    wait_got(gbase + 2);
    chk("t2_prod0", got_prod[gbase], 16'hFE01);
    chk("t2_prod1", got_prod[gbase + 1], 16'h0000);
    chk("t2_starts", n_starts - base, 2);

    // Back-pressure: one product held, four queued, sixth pair stalls.
    for (int i = 0; i < 6; i++) begin
      a3[i] = 8'(17 * i + 3);
      b3[i] = 8'(29 * i + 5);
    end
    bus.out_ready = 1'b0;
    gbase = got_prod.size();
    for (int i = 0; i < 5; i++) push(a3[i], b3[i], pc);
    wait_ov(t);
    chk("t3_full_count", bus.fifo_count, 4);
    chk("t3_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_a     = a3[5];
    bus.in_b     = b3[5];
    repeat (3) step();
    chk("t3_stall_count", bus.fifo_count, 4);
    bus.out_ready = 1'b1;
    push(a3[5], b3[5], pc);
    wait_got(gbase + 6);
    for (int i = 0; i < 6; i++) chk("t3_prod", got_prod[gbase + i], 16'(a3[i]) * 16'(b3[i]));
    chk("t3_drained", bus.fifo_count, 0);

    // Hung multiplier: watchdog fires, next pair still issues.
    mm_hang = 1;
    base    = n_starts;
    push(8'd5, 8'd6, pc);
    push(8'd7, 8'd8, pc);
    wait_starts(base + 1);
    mm_hang = 0;
    t = 0;
    while (bus.err_timeout !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) bound_fail("wait_err");
    chk("t4_err_cycle", cyc, start_cyc + 1 + TIMEOUT);
    chk("t4_no_ov", bus.out_valid, 0);
    wait_ov(t);
    chk("t4_next_product", bus.out_product, 16'd56);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("t4_err_clr", bus.err_timeout, 0);

    // Reset mid-WAIT with a pair still queued; the late done must be ignored.
    base = n_starts;
    push(8'd3, 8'd4, pc);
    push(8'd9, 8'd9, pc);
    wait_starts(base + 1);
    repeat (3) step();
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    repeat (12) step();
    chk("t5_out_valid",   bus.out_valid,   0);
    chk("t5_fifo_count",  bus.fifo_count,  0);
    chk("t5_out_product", bus.out_product, 0);
    chk("t5_mul_a",       bus.mul_a,       0);
    chk("t5_mul_b",       bus.mul_b,       0);
    chk("t5_err",         bus.err_timeout, 0);

    // Simultaneous push and pop leave the count unchanged.
    bus.out_ready = 1'b0;
    gbase = got_prod.size();
    push(8'd2, 8'd3, pc);
    wait_ov(t);
    push(8'd4, 8'd5, pc);
    push(8'd6, 8'd7, pc);
    repeat (2) step();
    chk("t6_count_before", bus.fifo_count, 2);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd8;
    bus.in_b      = 8'd9;
    step();
    bus.in_valid = 1'b0;
    chk("t6_count_pushpop", bus.fifo_count, 2);
    chk("t6_start", bus.mul_start, 1);
    bus.out_ready = 1'b1;
    wait_got(gbase + 4);
    chk("t6_prod0", got_prod[gbase], 16'd6);
    chk("t6_prod3", got_prod[gbase + 3], 16'd72);

    rand_mode = 1;
    repeat (600) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_a      = 8'($urandom);
      bus.in_b      = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.err_clr   = ($urandom_range(0, 19) == 0);
      wb_rst_i      = ($urandom_range(0, 299) == 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.err_clr   = 1'b0;
    wb_rst_i      = 1'b0;
    rand_mode     = 0;
    repeat (250) step();
    chk("final_drained", bus.fifo_count, 0);
    chk("final_out_valid", bus.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
